// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit sequencing FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes.
// Define CTRL_EXCEPT_EN to add the EXC state (undefined-instruction and ready-timeout traps).
module mc_ctrl #(
    parameter int ALUOP_W = 5,
    parameter int NPCOP_W = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               Zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               PCWr,
    output logic               IRWr,
    output logic               RFWr,
    output logic               DMWr,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [NPCOP_W-1:0] NPCOp,
    output logic               ASel,
    output logic               BSel,
    output logic [1:0]         EXTOp,
    output logic [1:0]         GPRSel,
    output logic [2:0]         WDSel,
    output logic               exc,
    output logic [2:0]         state
);

    localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] ALU_SLLV = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] ALU_SRLV = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] ALU_SRAV = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] ALU_BEQ  = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(17);
    localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(18);
    localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(19);

    localparam logic [NPCOP_W-1:0] NPC_PLUS4  = NPCOP_W'(0);
    localparam logic [NPCOP_W-1:0] NPC_BRANCH = NPCOP_W'(1);
    localparam logic [NPCOP_W-1:0] NPC_JUMP   = NPCOP_W'(2);
    localparam logic [NPCOP_W-1:0] NPC_JR     = NPCOP_W'(3);
`ifdef CTRL_EXCEPT_EN
    localparam logic [NPCOP_W-1:0] NPC_EXCEPT = NPCOP_W'(4);
`endif

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] GPR_RD   = 2'd0;
    localparam logic [1:0] GPR_RT   = 2'd1;
    localparam logic [1:0] GPR_31   = 2'd2;
    localparam logic [2:0] WD_ALU   = 3'd0;
    localparam logic [2:0] WD_MEM   = 3'd1;
    localparam logic [2:0] WD_PC    = 3'd2;

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef CTRL_EXCEPT_EN
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_EXC = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_t;
`endif

    typedef enum logic [3:0] {
        C_UNDEF, C_RTYPE, C_JR, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL
    } cls_t;

    state_t              r_state;
    state_t              w_next;
    logic [5:0]          r_opcode;
    logic [5:0]          r_funct;
    logic [WAIT_W-1:0]   r_wait;
    cls_t                w_cls;
    logic [ALUOP_W-1:0]  w_alu;
    logic                w_asel;
    logic                w_sext;
    logic                w_waiting;
`ifdef CTRL_EXCEPT_EN
    logic                w_timeout;
`endif

    // Instruction fields are captured only on the accepted fetch beat.
    always_ff @(posedge clk) begin
        if ((r_state == S_FETCH) && imem_ready) begin
            r_opcode <= opcode;
            r_funct  <= funct;
        end
    end

    always_comb begin
        w_cls  = C_UNDEF;
        w_alu  = ALU_NOP;
        w_asel = 1'b0;
        w_sext = 1'b0;
        case (r_opcode)
            6'h00: begin
                w_cls = C_RTYPE;
                case (r_funct)
                    6'h20:   w_alu = ALU_ADD;
                    6'h21:   w_alu = ALU_ADDU;
                    6'h22:   w_alu = ALU_SUB;
                    6'h23:   w_alu = ALU_SUBU;
                    6'h24:   w_alu = ALU_AND;
                    6'h25:   w_alu = ALU_OR;
                    6'h26:   w_alu = ALU_XOR;
                    6'h27:   w_alu = ALU_NOR;
                    6'h2A:   w_alu = ALU_SLT;
                    6'h2B:   w_alu = ALU_SLTU;
                    6'h00:   begin w_alu = ALU_SLL; w_asel = 1'b1; end
                    6'h02:   begin w_alu = ALU_SRL; w_asel = 1'b1; end
                    6'h03:   begin w_alu = ALU_SRA; w_asel = 1'b1; end
                    6'h04:   w_alu = ALU_SLLV;
                    6'h06:   w_alu = ALU_SRLV;
                    6'h07:   w_alu = ALU_SRAV;
                    6'h08:   w_cls = C_JR;
                    default: w_cls = C_UNDEF;
                endcase
            end
            6'h08:   begin w_cls = C_IALU; w_alu = ALU_ADD;  w_sext = 1'b1; end
            6'h09:   begin w_cls = C_IALU; w_alu = ALU_ADDU; w_sext = 1'b1; end
            6'h0A:   begin w_cls = C_IALU; w_alu = ALU_SLT;  end
            6'h0B:   begin w_cls = C_IALU; w_alu = ALU_SLTU; end
            6'h0C:   begin w_cls = C_IALU; w_alu = ALU_AND;  end
            6'h0D:   begin w_cls = C_IALU; w_alu = ALU_OR;   end
            6'h0E:   begin w_cls = C_IALU; w_alu = ALU_XOR;  end
            6'h0F:   begin w_cls = C_IALU; w_alu = ALU_LUI;  end
            6'h04:   begin w_cls = C_BR;   w_alu = ALU_BEQ;  end
            6'h05:   begin w_cls = C_BR;   w_alu = ALU_BNE;  end
            6'h23:   w_cls = C_LW;
            6'h2B:   w_cls = C_SW;
            6'h02:   w_cls = C_J;
            6'h03:   w_cls = C_JAL;
            default: w_cls = C_UNDEF;
        endcase
    end

    assign w_waiting = ((r_state == S_FETCH) && !imem_ready) ||
                       ((r_state == S_MEM)   && !dmem_ready);

`ifdef CTRL_EXCEPT_EN
    assign w_timeout = (TIMEOUT != 0) && w_waiting && (r_wait == WAIT_W'(TIMEOUT - 1));
`endif

    // Saturating wait counter; any state change restarts it.
    always_ff @(posedge clk) begin
        if (rst || (w_next != r_state)) begin
            r_wait <= '0;
        end else if (w_waiting && (r_wait != WAIT_W'(TIMEOUT))) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = rst ? 3'd0 : r_state;

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RFWr     = 1'b0;
        DMWr     = 1'b0;
        ALUOp    = ALU_NOP;
        NPCOp    = NPC_PLUS4;
        ASel     = 1'b0;
        BSel     = 1'b0;
        EXTOp    = EXT_ZERO;
        GPRSel   = GPR_RD;
        WDSel    = WD_ALU;
        exc      = 1'b0;
        // Every strobe is held low for the whole reset cycle.
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        IRWr   = 1'b1;
                        PCWr   = 1'b1;
                        NPCOp  = NPC_PLUS4;
                        w_next = S_DECODE;
                    end
`ifdef CTRL_EXCEPT_EN
                    else if (w_timeout) begin
                        w_next = S_EXC;
                    end
`endif
                end
                S_DECODE: begin
                    if (w_cls == C_UNDEF) begin
`ifdef CTRL_EXCEPT_EN
                        w_next = S_EXC;
`else
                        w_next = S_FETCH;
`endif
                    end else begin
                        w_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_next = S_FETCH;
                    case (w_cls)
                        C_RTYPE: begin
                            ALUOp  = w_alu;
                            ASel   = w_asel;
                            w_next = S_WB;
                        end
                        C_JR: begin
                            PCWr  = 1'b1;
                            NPCOp = NPC_JR;
                        end
                        C_IALU: begin
                            ALUOp  = w_alu;
                            BSel   = 1'b1;
                            EXTOp  = w_sext ? EXT_SIGN : EXT_ZERO;
                            w_next = S_WB;
                        end
                        C_LW, C_SW: begin
                            ALUOp  = ALU_ADD;
                            BSel   = 1'b1;
                            EXTOp  = EXT_SIGN;
                            w_next = S_MEM;
                        end
                        C_BR: begin
                            ALUOp = w_alu;
                            PCWr  = Zero;
                            NPCOp = NPC_BRANCH;
                        end
                        C_J: begin
                            PCWr  = 1'b1;
                            NPCOp = NPC_JUMP;
                        end
                        C_JAL: begin
                            PCWr   = 1'b1;
                            NPCOp  = NPC_JUMP;
                            RFWr   = 1'b1;
                            GPRSel = GPR_31;
                            WDSel  = WD_PC;
                        end
                        default: w_next = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    DMWr     = (w_cls == C_SW);
                    if (dmem_ready) begin
                        w_next = (w_cls == C_LW) ? S_WB : S_FETCH;
                    end
`ifdef CTRL_EXCEPT_EN
                    else if (w_timeout) begin
                        w_next = S_EXC;
                    end
`endif
                end
                S_WB: begin
                    RFWr   = 1'b1;
                    GPRSel = (w_cls == C_RTYPE) ? GPR_RD : GPR_RT;
                    WDSel  = (w_cls == C_LW) ? WD_MEM : WD_ALU;
                    w_next = S_FETCH;
                end
`ifdef CTRL_EXCEPT_EN
                S_EXC: begin
                    exc    = 1'b1;
                    PCWr   = 1'b1;
                    NPCOp  = NPC_EXCEPT;
                    w_next = S_FETCH;
                end
`endif
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle against hand-written control snapshots.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       PCWr;
    logic       IRWr;
    logic       RFWr;
    logic       DMWr;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic       ASel;
    logic       BSel;
    logic [1:0] EXTOp;
    logic [1:0] GPRSel;
    logic [2:0] WDSel;
    logic       exc;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       pcwr;
        logic       irwr;
        logic       rfwr;
        logic       dmwr;
        logic [4:0] aluop;
        logic [2:0] npcop;
        logic       asel;
        logic       bsel;
        logic [1:0] extop;
        logic [1:0] gprsel;
        logic [2:0] wdsel;
        logic       exc;
    } ctl_t;

    ctl_t got;
    ctl_t exp;

    always #5 clk = ~clk;

    mc_ctrl #(.ALUOP_W(5), .NPCOP_W(3), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .Zero       (Zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .RFWr       (RFWr),
        .DMWr       (DMWr),
        .ALUOp      (ALUOp),
        .NPCOp      (NPCOp),
        .ASel       (ASel),
        .BSel       (BSel),
        .EXTOp      (EXTOp),
        .GPRSel     (GPRSel),
        .WDSel      (WDSel),
        .exc        (exc),
        .state      (state)
    );

    function automatic ctl_t snap();
        ctl_t s;
        s.st       = state;
        s.imem_req = imem_req;
        s.dmem_req = dmem_req;
        s.pcwr     = PCWr;
        s.irwr     = IRWr;
        s.rfwr     = RFWr;
        s.dmwr     = DMWr;
        s.aluop    = ALUOp;
        s.npcop    = NPCOp;
        s.asel     = ASel;
        s.bsel     = BSel;
        s.extop    = EXTOp;
        s.gprsel   = GPRSel;
        s.wdsel    = WDSel;
        s.exc      = exc;
        return s;
    endfunction

    function automatic ctl_t idle_fetch();
        ctl_t s;
        s = '0;
        s.imem_req = 1'b1;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction on a ready beat; leaves the DUT in DECODE.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        imem_ready = 1'b1;
        opcode     = op;
        funct      = fn;
        tick();
        imem_ready = 1'b0;
        opcode     = 6'h3F;
        funct      = 6'h3F;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'h00; funct = 6'h00; Zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        tick(); tick(); #1;
        got = snap(); exp = '0; total++;
        if (got !== exp) $display("FAIL reset_hold: got %h expected %h", got, exp); else passed++;
        rst = 1'b0; #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL reset_release: got %h expected %h", got, exp); else passed++;
        tick();
    endtask

    task automatic test_rtype();
        opcode = 6'h00; funct = 6'h20; imem_ready = 1'b1; #1;
        got = snap(); exp = idle_fetch(); exp.irwr = 1'b1; exp.pcwr = 1'b1; total++;
        if (got !== exp) $display("FAIL rt_fetch: got %h expected %h", got, exp); else passed++;
        tick();
        opcode = 6'h3F; funct = 6'h3F; #1;
        got = snap(); exp = '0; exp.st = 3'd1; total++;
        if (got !== exp) $display("FAIL rt_decode: got %h expected %h", got, exp); else passed++;
        tick();
        imem_ready = 1'b0; #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd1; total++;
        if (got !== exp) $display("FAIL rt_exec: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd4; exp.rfwr = 1'b1; total++;
        if (got !== exp) $display("FAIL rt_wb: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL rt_done: got %h expected %h", got, exp); else passed++;
    endtask

    task automatic test_shift_itype();
        fetch(6'h00, 6'h00);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd9; exp.asel = 1'b1; total++;
        if (got !== exp) $display("FAIL sll_exec: got %h expected %h", got, exp); else passed++;
        tick(); tick();
        fetch(6'h0D, 6'h00);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd4; exp.bsel = 1'b1; total++;
        if (got !== exp) $display("FAIL ori_exec: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd4; exp.rfwr = 1'b1; exp.gprsel = 2'd1; total++;
        if (got !== exp) $display("FAIL ori_wb: got %h expected %h", got, exp); else passed++;
        tick();
        fetch(6'h08, 6'h00);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd1; exp.bsel = 1'b1; exp.extop = 2'd1; total++;
        if (got !== exp) $display("FAIL addi_exec: got %h expected %h", got, exp); else passed++;
        tick(); tick();
    endtask

    task automatic test_lw_wait();
        fetch(6'h23, 6'h00);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd1; exp.bsel = 1'b1; exp.extop = 2'd1; total++;
        if (got !== exp) $display("FAIL lw_exec: got %h expected %h", got, exp); else passed++;
        tick();
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            got = snap(); exp = '0; exp.st = 3'd3; exp.dmem_req = 1'b1; total++;
            if (got !== exp) $display("FAIL lw_mem_wait%0d: got %h expected %h", i, got, exp); else passed++;
            tick();
        end
        dmem_ready = 1'b1; #1;
        got = snap(); exp = '0; exp.st = 3'd3; exp.dmem_req = 1'b1; total++;
        if (got !== exp) $display("FAIL lw_mem_ready: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd4; exp.rfwr = 1'b1; exp.gprsel = 2'd1; exp.wdsel = 3'd1; total++;
        if (got !== exp) $display("FAIL lw_wb: got %h expected %h", got, exp); else passed++;
        tick();
        dmem_ready = 1'b0; #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL lw_done: got %h expected %h", got, exp); else passed++;
    endtask

    task automatic test_sw_reset();
        fetch(6'h2B, 6'h00);
        tick(); tick();
        dmem_ready = 1'b1; #1;
        got = snap(); exp = '0; exp.st = 3'd3; exp.dmem_req = 1'b1; exp.dmwr = 1'b1; total++;
        if (got !== exp) $display("FAIL sw_mem: got %h expected %h", got, exp); else passed++;
        tick();
        dmem_ready = 1'b0; #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL sw_done: got %h expected %h", got, exp); else passed++;
        fetch(6'h2B, 6'h00);
        tick(); tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd3; exp.dmem_req = 1'b1; exp.dmwr = 1'b1; total++;
        if (got !== exp) $display("FAIL sw_mem_wait: got %h expected %h", got, exp); else passed++;
        rst = 1'b1; #1;
        got = snap(); exp = '0; total++;
        if (got !== exp) $display("FAIL sw_rst_cycle: got %h expected %h", got, exp); else passed++;
        tick();
        rst = 1'b0; #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL sw_after_rst: got %h expected %h", got, exp); else passed++;
        tick();
    endtask

    task automatic test_branch();
        fetch(6'h04, 6'h00);
        tick();
        Zero = 1'b1; #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd16; exp.pcwr = 1'b1; exp.npcop = 3'd1; total++;
        if (got !== exp) $display("FAIL beq_taken: got %h expected %h", got, exp); else passed++;
        tick();
        Zero = 1'b0; #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL beq_taken_done: got %h expected %h", got, exp); else passed++;
        fetch(6'h04, 6'h00);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd16; exp.npcop = 3'd1; total++;
        if (got !== exp) $display("FAIL beq_not_taken: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL beq_nt_done: got %h expected %h", got, exp); else passed++;
        fetch(6'h05, 6'h00);
        tick();
        Zero = 1'b1; #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd17; exp.pcwr = 1'b1; exp.npcop = 3'd1; total++;
        if (got !== exp) $display("FAIL bne_exec: got %h expected %h", got, exp); else passed++;
        tick();
        Zero = 1'b0;
    endtask

    task automatic test_jumps();
        fetch(6'h03, 6'h00);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.pcwr = 1'b1; exp.npcop = 3'd2;
        exp.rfwr = 1'b1; exp.gprsel = 2'd2; exp.wdsel = 3'd2; total++;
        if (got !== exp) $display("FAIL jal_exec: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL jal_done: got %h expected %h", got, exp); else passed++;
        fetch(6'h02, 6'h00);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.pcwr = 1'b1; exp.npcop = 3'd2; total++;
        if (got !== exp) $display("FAIL j_exec: got %h expected %h", got, exp); else passed++;
        tick();
        fetch(6'h00, 6'h08);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.pcwr = 1'b1; exp.npcop = 3'd3; total++;
        if (got !== exp) $display("FAIL jr_exec: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL jr_done: got %h expected %h", got, exp); else passed++;
    endtask

    task automatic test_undefined();
        fetch(6'h3F, 6'h00);
        #1;
        got = snap(); exp = '0; exp.st = 3'd1; total++;
        if (got !== exp) $display("FAIL undef_decode: got %h expected %h", got, exp); else passed++;
        tick(); #1;
`ifdef CTRL_EXCEPT_EN
        got = snap(); exp = '0; exp.st = 3'd5; exp.exc = 1'b1; exp.pcwr = 1'b1; exp.npcop = 3'd4; total++;
        if (got !== exp) $display("FAIL undef_exc: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL undef_done: got %h expected %h", got, exp); else passed++;
`else
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL undef_nop: got %h expected %h", got, exp); else passed++;
`endif
    endtask

    task automatic test_timeout();
        imem_ready = 1'b0;
`ifdef CTRL_EXCEPT_EN
        for (int i = 0; i < 16; i++) begin
            #1;
            got = snap(); exp = idle_fetch(); total++;
            if (got !== exp) $display("FAIL timeout_wait%0d: got %h expected %h", i, got, exp); else passed++;
            tick();
        end
        #1;
        got = snap(); exp = '0; exp.st = 3'd5; exp.exc = 1'b1; exp.pcwr = 1'b1; exp.npcop = 3'd4; total++;
        if (got !== exp) $display("FAIL timeout_exc: got %h expected %h", got, exp); else passed++;
        tick(); #1;
        got = snap(); exp = idle_fetch(); total++;
        if (got !== exp) $display("FAIL timeout_done: got %h expected %h", got, exp); else passed++;
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            got = snap(); exp = idle_fetch(); total++;
            if (got !== exp) $display("FAIL no_timeout%0d: got %h expected %h", i, got, exp); else passed++;
            tick();
        end
`endif
        fetch(6'h00, 6'h20);
        tick(); #1;
        got = snap(); exp = '0; exp.st = 3'd2; exp.aluop = 5'd1; total++;
        if (got !== exp) $display("FAIL after_wait_exec: got %h expected %h", got, exp); else passed++;
        tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_shift_itype();
        test_lw_wait();
        test_sw_reset();
        test_branch();
        test_jumps();
        test_undefined();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath: a parametrised, sequential successor to the single-cycle decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath control set (RFWr, DMWr, ALUOp, NPCOp, ASel, BSel, EXTOp, GPRSel, WDSel) plus per-state PC/IR write strobes. Handshakes with instruction and data memory through req/ready pairs, so memories with variable latency are supported.

## Interface
- ALUOP_W, 5, ALUOp width
- NPCOP_W, 3, NPCOp width
- TIMEOUT, 16, max cycles waiting on any ready; 0 = wait forever
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction opcode, valid with imem_ready
- funct  in  6  instruction funct, valid with imem_ready
- Zero  in  1  ALU branch-condition result, sampled in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- PCWr  out  1  PC write strobe
- IRWr  out  1  instruction register write strobe
- RFWr, DMWr  out  1 each  register-file / data-memory write enable
- ALUOp  out  ALUOP_W  ALU operation (shared ctrl_encode_def codes)
- NPCOp  out  NPCOP_W  next-PC select (PLUS4/BRANCH/JUMP/JR/EXCEPT)
- ASel, BSel  out  1 each  ALU operand selects
- EXTOp, GPRSel  out  2 each  extend mode / destination select
- WDSel  out  3  write-data source
- exc  out  1  one-cycle exception pulse
- state  out  3  current state (debug)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5.
- FETCH: imem_req=1. On imem_ready: IRWr=1, PCWr=1 with NPCOp=PLUS4, latch opcode/funct, go DECODE.
- DECODE: classify latched instruction; all write enables 0; go EXEC.
- EXEC, per class:
  - R-type: ALUOp from funct, ASel=1 for SLL/SRL/SRA, otherwise 0; BSel=0; go WB.
  - JR: PCWr=1, NPCOp=JR; go FETCH.
  - I-type ALU: BSel=1, EXTOp signed for addi/addiu, else zero; go WB.
  - lw/sw: ALUOp=ADD, BSel=1, EXTOp signed; go MEM.
  - beq/bne: ALUOp=BEQ/BNE; PCWr=Zero, NPCOp=BRANCH; go FETCH.
  - j: PCWr=1, NPCOp=JUMP; go FETCH.
  - jal: PCWr=1, NPCOp=JUMP, RFWr=1, GPRSel=31, WDSel=FromPC; go FETCH.
- MEM: dmem_req=1, DMWr=1 for sw. On dmem_ready: sw goes FETCH, lw goes WB.
- WB: RFWr=1. GPRSel=RD for R-type, RT for I-type. WDSel=FromMem for lw, otherwise FromALU. Go FETCH.
- Control outputs are decoded from state plus latched fields. Every output not named for a state is 0.
- Wait counter: counts cycles in FETCH/MEM with ready low and clears on state change. At TIMEOUT, a bus error is raised (see Configuration).

## Timing
- Reset: state=FETCH. All outputs 0 during the reset cycle; imem_req=1 from the first cycle after reset.
- Instruction latency with zero-wait memory, measured FETCH to next FETCH:
  - R-type / I-type ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch / j / jal / jr: 3 cycles
- Each ready-low cycle in FETCH or MEM adds exactly one cycle.
- req stays high until the ready cycle. ready while req is low is ignored.
- Reset asserted mid-instruction: state returns to FETCH next cycle with no write strobes. A pending DMWr is dropped.
- Wait counter wraps never; it saturates at TIMEOUT.

## Configuration
- CTRL_EXCEPT_EN defined:
  - An undefined opcode/funct in DECODE, or a wait-counter timeout, goes to EXC.
  - EXC lasts 1 cycle: exc=1, PCWr=1, NPCOp=EXCEPT; then FETCH.
  - No RFWr/DMWr is issued for the faulting instruction.
- CTRL_EXCEPT_EN undefined:
  - Undefined instructions execute as NOP (DECODE→FETCH).
  - Timeout is ignored; the unit waits indefinitely.
  - exc is tied 0 and the EXC state is absent.

## Test plan
- R-type add, opcode=0x00 funct=0x20, ready immediate -> states 0,1,2,4,0. RFWr=1 only in WB, GPRSel=RD, WDSel=FromALU.
- lw, opcode=0x23, dmem_ready held low 3 cycles -> dmem_req high 4 cycles. WB has RFWr=1, WDSel=FromMem; total 8 cycles.
- beq, opcode=0x04, with Zero=1 then Zero=0 -> PCWr=1 with NPCOp=BRANCH in EXEC only when Zero=1; back to FETCH after 3 cycles.
- jal, opcode=0x03 -> in EXEC: PCWr=1, NPCOp=JUMP, RFWr=1, GPRSel=31, WDSel=FromPC.
- With CTRL_EXCEPT_EN: opcode=0x3F -> exc pulse 1 cycle, NPCOp=EXCEPT, no RFWr. With TIMEOUT=16 and imem_ready low -> exc at the 16th wait cycle.
- rst asserted during MEM of sw -> next cycle state=0, DMWr=0, dmem_req=0.
